// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter with a byte FIFO. Producers push bytes
//               through a valid/ready handshake. Each byte is serialized as
//               8N1 (start, 8 data bits LSB first, stop) at CLKS_PER_BIT
//               clocks per bit. Frames go out back-to-back while the FIFO
//               holds data.
//               Optional macro UART_TX_PARITY_EN inserts an even-parity bit
//               between the data bits and the stop bit (8E1 framing).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             txd,
  output logic             busy,
  output logic [FIFO_AW:0] fifo_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                 c_DEPTH     = 1 << FIFO_AW;
  localparam int                 c_CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_BAUD_ONE  = c_CNT_W'(1);
  localparam logic [FIFO_AW:0]   c_FULL      = (FIFO_AW + 1)'(c_DEPTH);
  localparam logic [FIFO_AW:0]   c_CNT_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   c_CNT_ZERO  = '0;
  localparam logic [FIFO_AW-1:0] c_PTR_ONE   = FIFO_AW'(1);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  logic [2:0]         state_q, state_d;
  logic [c_CNT_W-1:0] baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  logic [7:0]         mem_q [c_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  logic               w_push;
  logic               w_pop;
  logic               w_baud_end;
  logic               w_fifo_nonempty;
  logic [7:0]         w_head;

  // --------------------------------------------------------------------------
  // Handshake and status: all derived from registered state only, so there
  // is no combinational path from the FSM pop back to tx_ready.
  // --------------------------------------------------------------------------
  assign tx_ready        = (count_q != c_FULL);
  assign w_push          = tx_valid && tx_ready;
  assign w_fifo_nonempty = (count_q != c_CNT_ZERO);
  assign w_baud_end      = (baud_q == c_BAUD_LAST);
  assign w_head          = mem_q[rd_ptr_q];

  assign txd        = txd_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != c_ST_IDLE) || w_fifo_nonempty;

  // FIFO storage write; contents need no reset since pointers/count gate use
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO pointer and occupancy next-state; simultaneous push/pop holds count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + c_PTR_ONE;
    end
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_CNT_ONE;
      2'b01:   count_d = count_q - c_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: each non-idle state lasts one full baud period
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: begin
        if (w_fifo_nonempty) begin
          state_d = c_ST_START;
        end
      end
      c_ST_START: begin
        if (w_baud_end) begin
          state_d = c_ST_DATA;
        end
      end
      c_ST_DATA: begin
        if (w_baud_end && (bit_q == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = c_ST_PARITY;
`else
          state_d = c_ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      c_ST_PARITY: begin
        if (w_baud_end) begin
          state_d = c_ST_STOP;
        end
      end
`endif
      c_ST_STOP: begin
        // Go straight into the next start bit when more data waits
        if (w_baud_end) begin
          state_d = w_fifo_nonempty ? c_ST_START : c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  // FSM outputs: pop strobe, baud/bit counters, shifter and next txd level
  always_comb begin
    w_pop   = 1'b0;
    baud_d  = w_baud_end ? '0 : (baud_q + c_BAUD_ONE);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      c_ST_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
        if (w_fifo_nonempty) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^w_head;
`endif
        end
      end
      c_ST_START: begin
        txd_d = 1'b0;
        if (w_baud_end) begin
          bit_d = 3'd0;
          txd_d = shift_q[0];
        end
      end
      c_ST_DATA: begin
        // The shifter moves right so the current bit is always shift_q[0]
        if (w_baud_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            txd_d = parity_q;
`else
            txd_d = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            txd_d   = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      c_ST_PARITY: begin
        if (w_baud_end) begin
          txd_d = 1'b1;
        end
      end
`endif
      c_ST_STOP: begin
        txd_d = 1'b1;
        if (w_baud_end && w_fifo_nonempty) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          txd_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^w_head;
`endif
        end
      end
      default: begin
        baud_d = '0;
        txd_d  = 1'b1;
      end
    endcase
  end

  // Datapath registers; txd is registered so the line never glitches
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity of the byte in flight, captured when it is popped
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module      : tb_uart_tx
// Description : Scoreboard bench for uart_tx at CLKS_PER_BIT=4, FIFO_AW=4.
//               Stimulus pushes expected bytes into a queue; a serial-line
//               monitor decodes frames from txd and pops/compares.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

  localparam int CPB  = 4;
  localparam int HALF = CPB / 2;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME  = 11 * CPB;
  localparam int STOP_K = 10;
`else
  localparam int FRAME  = 10 * CPB;
  localparam int STOP_K = 9;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_count;

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  int         starts [$];
  logic       par_seen [$];
  int         frames_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy !== 1'b0 && n < bound) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- serial monitor ----------------
  int         cyc = 0;
  bit         mon_active = 1'b0;
  int         mon_t = 0;
  logic [7:0] mon_byte;
  logic       mon_par;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mon_active = 1'b0;
    end else if (mon_active) begin
      mon_t++;
    end else if (txd === 1'b0) begin
      mon_active = 1'b1;
      mon_t      = 0;
      starts.push_back(cyc);
    end
    if (mon_active && !reset) begin
      if (mon_t == HALF) chk("start_bit", {31'd0, txd}, 32'd0);
      for (int k = 1; k <= 8; k++) begin
        if (mon_t == k * CPB + HALF) mon_byte[k-1] = txd;
      end
      if (mon_t == 9 * CPB + HALF) mon_par = txd;
      if (mon_t == STOP_K * CPB + HALF) chk("stop_bit", {31'd0, txd}, 32'd1);
      if (mon_t == FRAME - 1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", {24'd0, mon_byte}, 32'hFFFF_FFFF);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("frame_data", {24'd0, mon_byte}, {24'd0, mon_exp});
`ifdef UART_TX_PARITY_EN
          chk("frame_parity", {31'd0, mon_par}, {31'd0, ^mon_exp});
          par_seen.push_back(mon_par);
`endif
        end
        frames_done++;
        mon_active = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int   n0;
    int   fd0;
    bit   ok;
    logic [7:0] b3 [3];
    int   target;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tick(); tick();
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_count", {27'd0, fifo_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Test 1: single 0x55 frame, latency and busy envelope
    tx_valid = 1'b1; tx_data = 8'h55; exp_q.push_back(8'h55);
    tick();                                     // E0
    tx_valid = 1'b0;
    chk("t1_count_after_push", {27'd0, fifo_count}, 32'd1);
    chk("t1_txd_idle_at_push", {31'd0, txd}, 32'd1);
    tick();                                     // E1
    chk("t1_start_latency", {31'd0, txd}, 32'd0);
    chk("t1_count_after_pop", {27'd0, fifo_count}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < FRAME - 1; i++) begin
      if (busy !== 1'b1) ok = 1'b0;
      tick();
    end
    if (busy !== 1'b1) ok = 1'b0;
    chk("t1_busy_through_frame", {31'd0, ok}, 32'd1);
    tick();                                     // E(FRAME+1)
    chk("t1_busy_falls", {31'd0, busy}, 32'd0);
    chk("t1_txd_high_after", {31'd0, txd}, 32'd1);

    // Test 2: three back-to-back frames
    n0 = starts.size();
    b3[0] = 8'hA5; b3[1] = 8'h00; b3[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = b3[i]; exp_q.push_back(b3[i]);
      tick();
    end
    tx_valid = 1'b0;
    wait_idle(400);
    chk("t2_frames_seen", starts.size() - n0, 32'd3);
    if (starts.size() >= n0 + 3) begin
      chk("t2_gap_1_2", starts[n0+1] - starts[n0], FRAME);
      chk("t2_total_span", starts[n0+2] + FRAME - starts[n0], 3 * FRAME);
    end

    // Test 3: 20 pushes with valid held; only the first 17 fit
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (tx_ready !== (k <= 16)) ok = 1'b0;
      tx_valid = 1'b1; tx_data = 8'h30 + 8'(k);
      if (k <= 16) exp_q.push_back(8'h30 + 8'(k));
      tick();                                   // E(k)
    end
    tx_valid = 1'b0;
    chk("t3_ready_pattern", {31'd0, ok}, 32'd1);
    chk("t3_count_full", {27'd0, fifo_count}, 32'd16);
    for (int i = 0; i < FRAME - 19; i++) tick(); // E(FRAME)
    chk("t3_ready_low_before_pop", {31'd0, tx_ready}, 32'd0);
    tick();                                     // E(FRAME+1)
    chk("t3_ready_after_pop", {31'd0, tx_ready}, 32'd1);
    chk("t3_count_after_pop", {27'd0, fifo_count}, 32'd15);
    wait_idle(20 * FRAME);
    chk("t3_scoreboard_drained", exp_q.size(), 32'd0);

    // Test 4: reset in the data bits of the second of three frames
    fd0 = frames_done;
    tx_valid = 1'b1; tx_data = 8'h11; exp_q.push_back(8'h11); tick();  // E0
    tx_data = 8'h22; tick();                                           // E1
    tx_data = 8'h33; tick();                                           // E2
    tx_valid = 1'b0;
    target = FRAME + 1 + CPB + 3 * CPB;
    for (int i = 0; i < target - 3; i++) tick();                       // E(target-1)
    reset = 1'b1;
    tick();                                                            // E(target)
    reset = 1'b0;
    chk("t4_txd", {31'd0, txd}, 32'd1);
    chk("t4_count", {27'd0, fifo_count}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_ready", {31'd0, tx_ready}, 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0) ok = 1'b0;
    end
    chk("t4_no_restart", {31'd0, ok}, 32'd1);
    chk("t4_frames_completed", frames_done - fd0, 32'd1);

    // Test 5: data toggling without valid is ignored
    ok = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tx_data = 8'($urandom);
      tx_valid = 1'b0;
      tick();
      if (txd !== 1'b1 || fifo_count !== 5'd0) ok = 1'b0;
    end
    chk("t5_ignore_data", {31'd0, ok}, 32'd1);

`ifdef UART_TX_PARITY_EN
    // Test 6: parity bits for 0x07 (three ones) and 0x03 (two ones)
    n0 = starts.size();
    tx_valid = 1'b1; tx_data = 8'h07; exp_q.push_back(8'h07); tick();
    tx_data = 8'h03; exp_q.push_back(8'h03); tick();
    tx_valid = 1'b0;
    wait_idle(300);
    chk("t6_parity_count", par_seen.size(), 32'd2);
    if (par_seen.size() >= 2) begin
      chk("t6_parity_07", {31'd0, par_seen[0]}, 32'd1);
      chk("t6_parity_03", {31'd0, par_seen[1]}, 32'd0);
    end
    if (starts.size() >= n0 + 2) chk("t6_frame_len", starts[n0+1] - starts[n0], 32'd44);
`endif

    tick(); tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter with a byte FIFO. Drives the board `txd` pin, the outbound companion to the `rxd` receive path in the miner top level.
- Other blocks (the result reporter and the processor MMIO) push bytes through a valid/ready handshake.
- The block serializes each byte as 8N1 at a fixed baud rate derived from the 100 MHz `clk`.
- Frames go out back-to-back while the FIFO holds data.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200 baud). Must be ≥2.
- FIFO_AW, 4, FIFO address width. Depth = 2^FIFO_AW = 16 entries.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to enqueue.
- tx_valid  input  1  producer offers tx_data this cycle.
- tx_ready  output  1  FIFO can accept a byte (not full).
- txd  output  1  serial line; idle high.
- busy  output  1  frame in progress or FIFO non-empty.
- fifo_count  output  FIFO_AW+1  bytes currently queued, 0..2^FIFO_AW.

Behaviour:
- Reset, sampled on the clk edge:
  - txd=1, busy=0, tx_ready=1, fifo_count=0.
  - State IDLE, baud counter 0, bit index 0, FIFO pointers 0.
- Reset mid-frame aborts the frame and flushes the FIFO. txd returns high on the cycle after the reset edge; no partial frame resumes.
- Push:
  - A byte is written on an edge where tx_valid && tx_ready.
  - tx_ready depends only on fifo_count != 2^FIFO_AW (registered-count based, no combinational path from the pop).
  - When full, a push is rejected even if a pop occurs in the same cycle.
  - tx_data is ignored when tx_valid=0.
- fifo_count: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. Pointers wrap modulo 2^FIFO_AW.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If fifo_count>0 at an edge, pop the head into the shift register, set baud counter to 0, go to START, txd=0. The first start bit therefore appears one cycle after the write edge that made the FIFO non-empty.
  - START: hold txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and txd=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 completes, go to STOP with txd=1.
  - STOP: hold txd=1 for CLKS_PER_BIT cycles. Then, if fifo_count>0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT−1. The state or bit advances on the edge where the counter equals CLKS_PER_BIT−1; the counter then wraps to 0.
- Frame length is exactly 10·CLKS_PER_BIT cycles.
- txd is a registered output; no glitches.
- busy = (state != IDLE) || (fifo_count != 0). busy falls on the cycle the last stop bit ends with the FIFO empty.
- A push on the same edge the FSM samples an empty FIFO in STOP/IDLE is not popped until the following edge.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP, held CLKS_PER_BIT cycles.
  - It transmits the even-parity bit (XOR of the 8 data bits).
  - Frame length becomes 11·CLKS_PER_BIT cycles.
- Undefined: no PARITY state; 8N1 framing as above; no parity logic synthesized.

Test Plan:
- CLKS_PER_BIT=4: release reset, push 0x55 once.
  - txd low 1 cycle after the push edge.
  - Then 4-cycle bits 0,1,0,1,0,1,0,1,0,1; frame lasts 40 cycles.
  - busy high throughout, low on cycle 41.
- Push 0xA5, 0x00, 0xFF on consecutive cycles.
  - Three contiguous frames totalling 120 cycles at CLKS_PER_BIT=4, no idle high between stop and next start.
  - Data bits decode LSB-first to A5, 00, FF.
- Push 20 bytes on 20 consecutive cycles with tx_valid held high.
  - First byte pops immediately.
  - fifo_count reaches 16 and tx_ready drops; exactly 17 bytes are accepted.
  - tx_ready reasserts on the first pop after the first frame.
  - The transmitted sequence equals the accepted bytes in order.
- Assert reset for 1 cycle mid-DATA of the second of 3 queued bytes.
  - txd=1, fifo_count=0, busy=0, tx_ready=1 the next cycle.
  - No further start bit without new pushes.
- Toggle tx_data randomly with tx_valid=0 for 200 cycles.
  - txd stays 1, fifo_count stays 0.
- With UART_TX_PARITY_EN, push 0x07 then 0x03.
  - Parity bits are 1 and 0.
  - Frames are 44 cycles each at CLKS_PER_BIT=4.
